// File: rtl/board_run_ctrl_if.sv
// Board run-controller bus: button/switch/probe inputs and CPU run-control outputs.
interface board_run_ctrl_if #(
  parameter int unsigned DW  = 8,
  parameter int unsigned NCH = 4,
  parameter int unsigned CW  = 16
);
  localparam int unsigned SW = (NCH > 1) ? $clog2(NCH) : 1;

  logic              btn_mode;
  logic              btn_step;
  logic [SW-1:0]     sw_sel;
  logic [NCH*DW-1:0] probe;
  logic              cpu_ce;
  logic              cpu_en;
  logic [1:0]        run_state;
  logic [CW-1:0]     cycle_cnt;
  logic [DW-1:0]     led;

  // Board side: drives buttons, switches and probes; observes run control.
  modport master (
    output btn_mode, btn_step, sw_sel, probe,
    input  cpu_ce, cpu_en, run_state, cycle_cnt, led
  );

  // Controller side.
  modport slave (
    input  btn_mode, btn_step, sw_sel, probe,
    output cpu_ce, cpu_en, run_state, cycle_cnt, led
  );
endinterface

// File: rtl/board_run_ctrl.sv
// Board-level HALT/RUN/STEP controller: debounced buttons, divided CPU clock
// enable, retired-cycle counter and LED view of a selectable debug channel.
module board_run_ctrl #(
  parameter int unsigned DIV       = 4,
  parameter int unsigned DB_CYCLES = 1000,
  parameter int unsigned DW        = 8,
  parameter int unsigned NCH       = 4,
  parameter int unsigned CW        = 16
) (
  input  logic               clk_undiv,
  input  logic               rst,
  board_run_ctrl_if.slave    bus
);

  localparam int unsigned SW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned DVW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int unsigned NB  = 2;
  localparam int unsigned BTN_MODE = 0;
  localparam int unsigned BTN_STEP = 1;

  localparam logic [DVW-1:0] DIV_LAST = DVW'(DIV - 1);
  localparam logic [DBW-1:0] DB_LAST  = DBW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_HALT = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10
  } state_e;

  // Button path state (index 0 = mode, index 1 = step)
  logic [NB-1:0]          btn_raw;
  logic [NB-1:0]          sync1_q, sync1_d;
  logic [NB-1:0]          sync2_q, sync2_d;
  logic [NB-1:0]          db_lvl_q, db_lvl_d;
  logic [NB-1:0][DBW-1:0] db_cnt_q, db_cnt_d;
  logic [NB-1:0]          strobe_q, strobe_d;

  // Run control state
  state_e                 state_q, state_d;
  logic [DVW-1:0]         div_q, div_d;
  logic                   cpu_ce_q, cpu_ce_d;
  logic                   cpu_en_q, cpu_en_d;
  logic [CW-1:0]          cycle_cnt_q, cycle_cnt_d;
  logic [DW-1:0]          led_q, led_d;

  logic                   mode_stb;
  logic                   step_stb;

  assign btn_raw  = {bus.btn_step, bus.btn_mode};
  assign mode_stb = strobe_q[BTN_MODE];
  assign step_stb = strobe_q[BTN_STEP];

  // Synchronise, debounce and detect the accepted rising edge of each button.
  always_comb begin
    sync1_d  = btn_raw;
    sync2_d  = sync1_q;
    db_lvl_d = db_lvl_q;
    db_cnt_d = db_cnt_q;
    strobe_d = '0;
    for (int i = 0; i < NB; i++) begin
      if (sync2_q[i] == db_lvl_q[i]) begin
        // Back at the accepted level: any run of differing samples is a bounce.
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_LAST) begin
        // This is the DB_CYCLES-th consecutive differing sample: accept it.
        db_cnt_d[i] = '0;
        db_lvl_d[i] = sync2_q[i];
        strobe_d[i] = sync2_q[i];
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DBW'(1);
      end
    end
  end

  // Button path registers.
  always_ff @(posedge clk_undiv or negedge rst) begin
    if (!rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      db_lvl_q <= '0;
      db_cnt_q <= '0;
      strobe_q <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      db_lvl_q <= db_lvl_d;
      db_cnt_q <= db_cnt_d;
      strobe_q <= strobe_d;
    end
  end

  // Run-state transitions; mode strobe wins over step strobe.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HALT: begin
        if (mode_stb) begin
          state_d = ST_RUN;
        end else if (step_stb) begin
          state_d = ST_STEP;
        end
      end
      ST_RUN: begin
        if (mode_stb) begin
          state_d = ST_HALT;
        end
      end
      ST_STEP: begin
        state_d = mode_stb ? ST_RUN : ST_HALT;
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_undiv or negedge rst) begin
    if (!rst) begin
      state_q <= ST_HALT;
    end else begin
      state_q <= state_d;
    end
  end

  // Divider, clock enable, enable, retired-cycle count and LED mux.
  always_comb begin
    div_d       = '0;
    cpu_ce_d    = 1'b0;
    cpu_en_d    = (state_q != ST_HALT);
    cycle_cnt_d = cycle_cnt_q + CW'(cpu_ce_q);
    led_d       = '0;

    // The divider is zero in every non-RUN state, so each RUN entry starts at 0.
    if (state_q == ST_RUN) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DVW'(1);
    end

    if (((state_q == ST_RUN) && (div_q == DIV_LAST)) || (state_q == ST_STEP)) begin
      cpu_ce_d = 1'b1;
    end

    // Unmatched selects (non-power-of-two NCH) leave the LED dark.
    for (int k = 0; k < NCH; k++) begin
      if (bus.sw_sel == SW'(k)) begin
        led_d = bus.probe[k*DW +: DW];
      end
    end
  end

  // Output and datapath registers.
  always_ff @(posedge clk_undiv or negedge rst) begin
    if (!rst) begin
      div_q       <= '0;
      cpu_ce_q    <= 1'b0;
      cpu_en_q    <= 1'b0;
      cycle_cnt_q <= '0;
      led_q       <= '0;
    end else begin
      div_q       <= div_d;
      cpu_ce_q    <= cpu_ce_d;
      cpu_en_q    <= cpu_en_d;
      cycle_cnt_q <= cycle_cnt_d;
      led_q       <= led_d;
    end
  end

  assign bus.cpu_ce    = cpu_ce_q;
  assign bus.cpu_en    = cpu_en_q;
  assign bus.run_state = state_q;
  assign bus.cycle_cnt = cycle_cnt_q;
  assign bus.led       = led_q;

endmodule
